commit_mem_write_ctrl2axi: RTL
==============================

// Module: commit_mem_write_ctrl2axi
// PURPOSE
//  Write-side AXI4 initiator for the commit stage. Accepts one committed store request at a time.
//  Two request kinds: an uncached single-beat store, or a dirty D-cache line writeback (8 x 32b INCR burst).
//  Drives AW/W/B, reports completion to the store path, and blocks new requests while busy.
// PARAMETERS
//  none. Line = 8 words (32 B) and AXI ID = 0 are fixed.
// PORTS
//  clk               in   1    clock; single clock domain
//  resetn            in   1    asynchronous, active-low reset
//  s_busy            out  1    1 when state != IDLE
//  i_ctrl_en         in   1    request valid; sampled only in IDLE
//  i_ctrl_fid        in   8    instruction/flow id, used for duplicate suppression
//  i_ctrl_addr       in   32   store byte address, or any address inside the victim line
//  i_ctrl_uncached   in   1    1 = single-beat uncached store; 0 = line writeback
//  i_ctrl_lswidth    in   2    `LSWIDTH_BYTE / `LSWIDTH_HALF / `LSWIDTH_WORD (uncached only)
//  i_ctrl_data       in   32   store data, right-aligned (uncached only)
//  i_ctrl_line       in   256  victim line; word k = bits [32k+31:32k] (writeback only)
//  o_done            out  1    1-cycle pulse on the B handshake
//  o_err             out  1    valid with o_done; equals bresp[1] (SLVERR/DECERR)
//  axi_m_awid/awaddr/awlen/awsize/awburst/awuser/awvalid  out  4/32/8/3/2/1/1
//  axi_m_awready     in   1
//  axi_m_wdata/wstrb/wlast/wvalid  out  32/4/1/1
//  axi_m_wready      in   1
//  axi_m_bid/bresp/bvalid  in  4/2/1
//  axi_m_bready      out  1
// BEHAVIOUR
//  Reset: all state, tags and AXI regs clear; every output is 0; state = IDLE. Reset is async, so
//    asserting it mid-burst drops awvalid/wvalid immediately. No resume is attempted.
//  States: IDLE -> REQ -> (BURST) -> RESP -> IDLE.
//  IDLE, i_ctrl_en=1, fid tag valid and i_ctrl_fid == tag: request is dropped and the block stays IDLE.
//  IDLE, i_ctrl_en=1, otherwise: capture addr/data/line, set tag={1,fid}, load AW/W regs, go to REQ.
//  IDLE, i_ctrl_en=0: clear tag valid.
//  Uncached request:
//    awaddr = addr (unaligned); awlen = 0; awburst = FIXED; awuser = 1
//    awsize = 000 / 001 / 010 for byte / half / word
//    wstrb: byte = 4'b0001 << addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111
//    wdata = data << (8*addr[1:0]); wlast = 1
//  Writeback request:
//    awaddr = {addr[31:5], 5'b0}; awlen = 7; awsize = 010; awburst = INCR; awuser = 0
//    wstrb = 4'b1111; wdata = line word[beat]
//  REQ: awvalid and the first wvalid rise together, one cycle after acceptance.
//    Independent aw_done / w_done flags; each valid drops on its own handshake, in any order.
//    Uncached: go to RESP once both are done (either simultaneously or in either order).
//    Writeback: 3-bit beat counter advances on each W handshake; wlast = (beat == 7).
//      wvalid stays high and wdata updates in the same cycle as the handshake (no bubbles).
//      Go to RESP when aw_done and the beat-7 handshake have both occurred.
//  W may complete before AW; the block never waits on AW to present W.
//  RESP: bready = 1. On bvalid: o_done = 1, o_err = bresp[1], go to IDLE.
//    bvalid while not in RESP is ignored.
//  Outputs are registered, except o_done/o_err, which are combinational from bvalid in RESP.
//  bid is ignored; awid = 0.
// STRUCTURE
//  Shared define file: `LSWIDTH_* (BYTE=2'b00, HALF=2'b01, WORD=2'b10),
//    `AXI_BURST_LEN_1/_8, `AXI_BURST_SIZE_1/_2/_4, `AXI_BURST_TYPE_*.
//  State encodings (`MEMW_STATE_*) stay local to this file.
//  One combinational sub-module, commit_mem_write_strbgen:
//    (lswidth, addr[1:0], data) -> (wstrb, shifted wdata, awsize).
// TESTING
//  1. Uncached byte store, addr 0x1FD0_0003, data 0xA5, awready/wready = 1, B OKAY ->
//     awsize 000, wstrb 1000, wdata 0xA500_0000; o_done exactly 1 cycle; o_err 0.
//  2. Uncached half store at addr 0x...2; wready 3 cycles before awready -> wstrb 1100,
//     W handshake completes first, RESP entered only after AW.
//  3. Writeback, addr 0x8000_1234, line words k = 0x1111_1111*k, wready toggling every cycle ->
//     awaddr 0x8000_1220, awlen 7, INCR; 8 beats in order; wlast only on beat 7.
//  4. i_ctrl_en held with the same fid across o_done -> exactly one AW issued.
//     Then en low 1 cycle and the same fid reissued -> second AW issued.
//  5. bresp = 2'b10 -> o_err = 1 with o_done; s_busy falls the next cycle.
//  6. resetn asserted at burst beat 4 -> awvalid/wvalid/s_busy = 0 asynchronously.
//     After release, a new uncached request completes normally.

Source files
------------

// File: rtl/commit_mem_write_ctrl2axi_pkg.sv
// Shared constants and types for the commit-stage AXI write initiator.
//   - load/store width codes as carried on i_ctrl_lswidth
//   - AXI burst length / size / type encodings
//   - line_t: one D-cache line viewed as 8 x 32-bit words (word k at bits [32k+31:32k])
package commit_mem_write_ctrl2axi_pkg;

    localparam logic [1:0] LsWidthByte = 2'b00;
    localparam logic [1:0] LsWidthHalf = 2'b01;
    localparam logic [1:0] LsWidthWord = 2'b10;

    localparam logic [7:0] AxiBurstLen1 = 8'd0;
    localparam logic [7:0] AxiBurstLen8 = 8'd7;

    localparam logic [2:0] AxiBurstSize1 = 3'b000;
    localparam logic [2:0] AxiBurstSize2 = 3'b001;
    localparam logic [2:0] AxiBurstSize4 = 3'b010;

    localparam logic [1:0] AxiBurstTypeFixed = 2'b00;
    localparam logic [1:0] AxiBurstTypeIncr  = 2'b01;
    localparam logic [1:0] AxiBurstTypeWrap  = 2'b10;

    localparam int unsigned LineWords = 8;

    typedef logic [LineWords-1:0][31:0] line_t;

endpackage

// File: rtl/commit_mem_write_strbgen.sv
// Byte-lane steering for a single uncached store.
// Ports:
//   lswidth_i  access width code (byte / half / word)
//   addr_lo_i  byte offset within the 32-bit word
//   data_i     right-aligned store data
//   wstrb_o    write strobes for the AXI W beat
//   wdata_o    store data shifted onto its byte lanes
//   awsize_o   AXI AWSIZE matching the access width
module commit_mem_write_strbgen
    import commit_mem_write_ctrl2axi_pkg::*;
(
    input  logic [1:0]  lswidth_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [2:0]  awsize_o
);

    always_comb begin
        wdata_o = data_i << {addr_lo_i, 3'b000};
        case (lswidth_i)
            LsWidthByte: begin
                wstrb_o  = 4'b0001 << addr_lo_i;
                awsize_o = AxiBurstSize1;
            end
            LsWidthHalf: begin
                // Halves are lane-aligned on addr[1]; addr[0] does not move the strobes.
                wstrb_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                awsize_o = AxiBurstSize2;
            end
            default: begin
                wstrb_o  = 4'b1111;
                awsize_o = AxiBurstSize4;
            end
        endcase
    end

endmodule

// File: rtl/commit_mem_write_ctrl2axi.sv
// Write-side AXI4 initiator for the commit stage. Takes one committed store at a time:
// either an uncached single-beat store or an 8-beat INCR writeback of a dirty line.
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   s_busy                high whenever a request is in flight
//   i_ctrl_*              request (en, fid, addr, uncached, lswidth, data, line)
//   o_done / o_err        one-cycle completion pulse on the B handshake, error = bresp[1]
//   axi_m_aw* / w* / b*   AXI4 write address, write data and response channels (ID fixed 0)
module commit_mem_write_ctrl2axi
    import commit_mem_write_ctrl2axi_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    output logic         s_busy,
    input  logic         i_ctrl_en,
    input  logic [7:0]   i_ctrl_fid,
    input  logic [31:0]  i_ctrl_addr,
    input  logic         i_ctrl_uncached,
    input  logic [1:0]   i_ctrl_lswidth,
    input  logic [31:0]  i_ctrl_data,
    input  logic [255:0] i_ctrl_line,
    output logic         o_done,
    output logic         o_err,
    output logic [3:0]   axi_m_awid,
    output logic [31:0]  axi_m_awaddr,
    output logic [7:0]   axi_m_awlen,
    output logic [2:0]   axi_m_awsize,
    output logic [1:0]   axi_m_awburst,
    output logic         axi_m_awuser,
    output logic         axi_m_awvalid,
    input  logic         axi_m_awready,
    output logic [31:0]  axi_m_wdata,
    output logic [3:0]   axi_m_wstrb,
    output logic         axi_m_wlast,
    output logic         axi_m_wvalid,
    input  logic         axi_m_wready,
    input  logic [3:0]   axi_m_bid,
    input  logic [1:0]   axi_m_bresp,
    input  logic         axi_m_bvalid,
    output logic         axi_m_bready
);

    // Uncached stores and line writebacks share StReq; wlast tells them apart.
    typedef enum logic [1:0] {StIdle, StReq, StResp} memw_state_e;

    memw_state_e state_q, state_d;
    logic        tag_vld_q, tag_vld_d;
    logic [7:0]  tag_fid_q, tag_fid_d;
    line_t       line_q, line_d;
    logic [2:0]  beat_q, beat_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [7:0]  awlen_q, awlen_d;
    logic [2:0]  awsize_q, awsize_d;
    logic [1:0]  awburst_q, awburst_d;
    logic        awuser_q, awuser_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        wlast_q, wlast_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;

    logic [3:0]  sg_wstrb;
    logic [31:0] sg_wdata;
    logic [2:0]  sg_awsize;
    logic        aw_hs, w_hs;
    logic [2:0]  next_beat;
    line_t       req_line;

    logic unused_b;
    assign unused_b = ^{axi_m_bid, axi_m_bresp[0]};

    commit_mem_write_strbgen u_strbgen (
        .lswidth_i (i_ctrl_lswidth),
        .addr_lo_i (i_ctrl_addr[1:0]),
        .data_i    (i_ctrl_data),
        .wstrb_o   (sg_wstrb),
        .wdata_o   (sg_wdata),
        .awsize_o  (sg_awsize)
    );

    assign req_line  = i_ctrl_line;
    assign aw_hs     = axi_m_awvalid & axi_m_awready;
    assign w_hs      = axi_m_wvalid & axi_m_wready;
    assign next_beat = beat_q + 3'd1;

    always_comb begin
        state_d   = state_q;
        tag_vld_d = tag_vld_q;
        tag_fid_d = tag_fid_q;
        line_d    = line_q;
        beat_d    = beat_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awsize_d  = awsize_q;
        awburst_d = awburst_q;
        awuser_d  = awuser_q;
        awvalid_d = awvalid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wlast_d   = wlast_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;

        case (state_q)
            StIdle: begin
                if (!i_ctrl_en) begin
                    tag_vld_d = 1'b0;
                end else if (!(tag_vld_q && (i_ctrl_fid == tag_fid_q))) begin
                    // A request whose fid matches the last accepted one is a replay; drop it.
                    tag_vld_d = 1'b1;
                    tag_fid_d = i_ctrl_fid;
                    line_d    = req_line;
                    beat_d    = 3'd0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = StReq;
                    if (i_ctrl_uncached) begin
                        awaddr_d  = i_ctrl_addr;
                        awlen_d   = AxiBurstLen1;
                        awsize_d  = sg_awsize;
                        awburst_d = AxiBurstTypeFixed;
                        awuser_d  = 1'b1;
                        wdata_d   = sg_wdata;
                        wstrb_d   = sg_wstrb;
                        wlast_d   = 1'b1;
                    end else begin
                        awaddr_d  = {i_ctrl_addr[31:5], 5'b0};
                        awlen_d   = AxiBurstLen8;
                        awsize_d  = AxiBurstSize4;
                        awburst_d = AxiBurstTypeIncr;
                        awuser_d  = 1'b0;
                        wdata_d   = req_line[0];
                        wstrb_d   = 4'b1111;
                        wlast_d   = 1'b0;
                    end
                end
            end
            StReq: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    if (wlast_q) begin
                        wvalid_d = 1'b0;
                        w_done_d = 1'b1;
                    end else begin
                        // Present the next word in the same cycle: no bubble between beats.
                        beat_d  = next_beat;
                        wdata_d = line_q[next_beat];
                        wlast_d = (next_beat == 3'd7);
                    end
                end
                if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && wlast_q))) begin
                    bready_d = 1'b1;
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (axi_m_bvalid) begin
                    bready_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            tag_vld_q <= 1'b0;
            tag_fid_q <= '0;
            line_q    <= '0;
            beat_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            awuser_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wlast_q   <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_vld_q <= tag_vld_d;
            tag_fid_q <= tag_fid_d;
            line_q    <= line_d;
            beat_q    <= beat_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            awburst_q <= awburst_d;
            awuser_q  <= awuser_d;
            awvalid_q <= awvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wlast_q   <= wlast_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    assign s_busy        = (state_q != StIdle);
    assign o_done        = (state_q == StResp) && axi_m_bvalid;
    assign o_err         = o_done && axi_m_bresp[1];
    assign axi_m_awid    = 4'd0;
    assign axi_m_awaddr  = awaddr_q;
    assign axi_m_awlen   = awlen_q;
    assign axi_m_awsize  = awsize_q;
    assign axi_m_awburst = awburst_q;
    assign axi_m_awuser  = awuser_q;
    assign axi_m_awvalid = awvalid_q;
    assign axi_m_wdata   = wdata_q;
    assign axi_m_wstrb   = wstrb_q;
    assign axi_m_wlast   = wlast_q;
    assign axi_m_wvalid  = wvalid_q;
    assign axi_m_bready  = bready_q;

endmodule
